riscv_lsu: RTL
==============

# riscv_lsu

Load/store unit that initiates data accesses on the data port of `riscv_ram`, the byte-addressed RAM with combinational 32-bit read and synchronous 32-bit write. Sits between the core's execute stage and the RAM data port. It converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM transactions: extraction with sign/zero extension for loads, and read-modify-write for sub-word stores. It checks alignment, range and funct3 legality, and returns results on a valid/ready response channel.

## Interface
- `WORD_LENGTH`, 32, data/address width
- `NUM_MEM`, 16384, RAM size in bytes; valid byte addresses 0..NUM_MEM-1
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width/sign code
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; low byte/halfword used for SB/SH
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  2  0 OK, 1 misaligned, 2 out of range, 3 illegal funct3
- `mem_addr`  out  32  to RAM `addr`
- `mem_we`  out  1  to RAM `write_en`
- `mem_wdata`  out  32  to RAM `wdata`
- `mem_rdata`  in  32  from RAM `dout`, combinational

## Operation
- States: IDLE, LOAD, RMW, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch we/funct3/addr/wdata.
  - Error → RESP.
  - Load → LOAD.
  - SW → WRITE, with merged word = wdata.
  - SB/SH → RMW.
- LOAD: `mem_addr`=latched addr. Capture `mem_rdata` into the extracted, extended result. → RESP.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: as-is.
- RMW: `mem_addr`=latched addr. Capture `mem_rdata` and replace bits [7:0] (SB) or [15:0] (SH) with wdata. → WRITE.
- WRITE: `mem_we`=1, `mem_wdata`=merged word, `mem_addr`=latched addr, one cycle only. → RESP.
- RESP: `resp_valid`=1; rdata and err held stable. Go to IDLE on `resp_ready`.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is error 3.
- Misaligned (error 1): halfword with addr[0]≠0; word with addr[1:0]≠0.
- Range (error 2): addr+size > NUM_MEM, where size is 1/2/4. Compute at 33 bits so 0xFFFFFFFC+4 does not wrap.
- Error priority: 3 > 1 > 2. An errored request issues no RAM access; `mem_we` stays 0.
- `mem_addr` is driven from the latched address register in every state. `mem_wdata` is driven from the merge register.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all latches 0.
- Cycle numbering: request accepted on edge of cycle 0.
- Latency to `resp_valid` high:
  - Load: cycle 2 (LOAD in cycle 1).
  - SW: cycle 2 (WRITE in cycle 1; RAM updated at end of cycle 1).
  - SB/SH: cycle 3 (RMW cycle 1, WRITE cycle 2).
  - Error: cycle 1.
- One outstanding request. `req_ready`=0 in every non-IDLE state, including RESP. No same-cycle response-to-request bypass.
- `resp_ready` asserted with `resp_valid`: handshake completes on that edge, and `req_ready` is 1 the next cycle.
- Backpressure: RESP holds indefinitely. No further RAM writes occur while waiting.
- Reset mid-operation: `mem_we` = (state==WRITE) && `rst_n`, so no write commits on an edge where `rst_n`=0. Any in-flight request is dropped without response.

## Structure
- Package `riscv_lsu_pkg`:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum `lsu_state_t`.
  - Error enum `lsu_err_t` (`ERR_NONE`, `ERR_MISALIGN`, `ERR_RANGE`, `ERR_FUNCT3`).
- Sub-module `riscv_lsu_align`: purely combinational.
  - Load extraction/extension.
  - Store merge.
  - Legality/range check.
- FSM and registers live in `riscv_lsu`.

## Test plan
- RAM word 0x100 = 0x8000_00F0; LB at 0x100 → resp_rdata 0xFFFF_FFF0, err 0, resp_valid in cycle 2. LBU → 0x0000_00F0. LH → 0xFFFF_80F0 is wrong; expect 0x0000_00F0 for LH, and 0x8000_00F0 for LW.
- RAM 0x200 = 0x1122_3344; SB 0xAB at 0x200 → `mem_we` high exactly one cycle (cycle 2), RAM 0x200 = 0x1122_33AB, resp cycle 3. SH 0xBEEF → 0x1122_BEEF.
- SW 0xDEAD_BEEF at 0x3FFC (NUM_MEM=16384) → OK, RAM updated. LW at 0x4000 → err 2. LW at 0xFFFF_FFFC → err 2 with no wrap. LH at 0x101 → err 1. Load funct3 011 → err 3. Store funct3 100 → err 3. Every error: resp cycle 1, `mem_we` never high.
- Hold `resp_ready`=0 for 5 cycles after SW: resp_valid, rdata, err stable; `req_ready`=0; single write only. Then assert `resp_ready`: `req_ready`=1 the next cycle.
- Deassert `rst_n` while in WRITE of an SB: RAM unchanged, no resp_valid, all outputs at reset values the next cycle. The next request proceeds normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package riscv_lsu_pkg;

  // RV32I load/store width and sign codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RMW   = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_FUNCT3   = 2'd3
  } lsu_err_t;

  // Access size in bytes from the low two funct3 bits (byte/half/word)
  function automatic logic [2:0] access_size(input logic [1:0] w);
    case (w)
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational helpers: request legality/range check, load extraction
// with sign/zero extension, and sub-word store merge.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 16384
) (
  input  logic                   chk_we,
  input  logic [2:0]             chk_funct3,
  input  logic [WORD_LENGTH-1:0] chk_addr,
  output logic [1:0]             chk_err,
  input  logic [2:0]             ld_funct3,
  input  logic [WORD_LENGTH-1:0] ld_rdata,
  output logic [WORD_LENGTH-1:0] ld_data,
  input  logic [2:0]             st_funct3,
  input  logic [WORD_LENGTH-1:0] st_old,
  input  logic [WORD_LENGTH-1:0] st_wdata,
  output logic [WORD_LENGTH-1:0] st_merged
);

  logic                 f3_ok;
  logic                 misalign;
  logic                 out_of_range;
  logic [2:0]           size;
  logic [WORD_LENGTH:0] end_addr;

  // Legality: funct3 beats alignment beats range; end address is one bit wider so it never wraps
  always_comb begin
    if (chk_we) f3_ok = chk_funct3 inside {F3_B, F3_H, F3_W};
    else        f3_ok = chk_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misalign = ((chk_funct3[1:0] == 2'b01) && chk_addr[0]) ||
               ((chk_funct3[1:0] == 2'b10) && (chk_addr[1:0] != 2'b00));
    size         = access_size(chk_funct3[1:0]);
    end_addr     = {1'b0, chk_addr} + {{(WORD_LENGTH-2){1'b0}}, size};
    out_of_range = end_addr > (WORD_LENGTH+1)'(NUM_MEM);
    if (!f3_ok)            chk_err = ERR_FUNCT3;
    else if (misalign)     chk_err = ERR_MISALIGN;
    else if (out_of_range) chk_err = ERR_RANGE;
    else                   chk_err = ERR_NONE;
  end

  // Load extraction from the low bits of the RAM word at the access address
  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{(WORD_LENGTH-8){ld_rdata[7]}}, ld_rdata[7:0]};
      F3_H:    ld_data = {{(WORD_LENGTH-16){ld_rdata[15]}}, ld_rdata[15:0]};
      F3_BU:   ld_data = {{(WORD_LENGTH-8){1'b0}}, ld_rdata[7:0]};
      F3_HU:   ld_data = {{(WORD_LENGTH-16){1'b0}}, ld_rdata[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

  // Store merge: sub-word stores keep the upper bytes of the old RAM word
  always_comb begin
    case (st_funct3)
      F3_B:    st_merged = {st_old[WORD_LENGTH-1:8], st_wdata[7:0]};
      F3_H:    st_merged = {st_old[WORD_LENGTH-1:16], st_wdata[15:0]};
      default: st_merged = st_wdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit between the execute stage and the RAM data port.
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. Only one
// request is outstanding; req_ready is high only in IDLE, and the response holds
// its data and error stable until it is accepted.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 16384
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic [1:0]             resp_err,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);

  lsu_state_t             state_q, state_d;
  logic [2:0]             f3_q;
  logic [WORD_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic [WORD_LENGTH-1:0] merge_q;
  logic [WORD_LENGTH-1:0] rdata_q;
  logic [1:0]             err_q;
  logic [1:0]             chk_err;
  logic [WORD_LENGTH-1:0] ld_data;
  logic [WORD_LENGTH-1:0] st_merged;

  riscv_lsu_align #(
    .WORD_LENGTH (WORD_LENGTH),
    .NUM_MEM     (NUM_MEM)
  ) u_align (
    .chk_we     (req_we),
    .chk_funct3 (req_funct3),
    .chk_addr   (req_addr),
    .chk_err    (chk_err),
    .ld_funct3  (f3_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data),
    .st_funct3  (f3_q),
    .st_old     (mem_rdata),
    .st_wdata   (wdata_q),
    .st_merged  (st_merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: errors skip the RAM, SW writes directly, SB/SH read first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (chk_err != ERR_NONE) state_d = S_RESP;
          else if (!req_we)        state_d = S_LOAD;
          else if (req_funct3 == F3_W) state_d = S_WRITE;
          else                     state_d = S_RMW;
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_RMW:   state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, merge word and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            merge_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= chk_err;
          end
        end
        S_LOAD:  rdata_q <= ld_data;
        S_RMW:   merge_q <= st_merged;
        default: ;
      endcase
    end
  end

  // Write strobe is gated by reset so an in-flight write never commits during reset
  assign mem_we     = (state_q == S_WRITE) && rst_n;
  assign mem_addr   = addr_q;
  assign mem_wdata  = merge_q;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
